// File: rtl/srch_arbiter_if.sv
// rtl/srch_arbiter_if.sv - requester and control-unit signal bundle for srch_arbiter
interface srch_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = 8
);
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    din_vld;
    logic [NREQ*DW-1:0] din;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    done;
    logic               ovf_o;
    logic               udf_o;
    logic               tmo_err;
    logic               busy;
    logic               srch;
    logic               dtin;
    logic [DW-1:0]      data_o;
    logic               seach_end;
    logic               overflow;
    logic               underflow;

    // master: requesters plus control unit; slave: the arbiter itself
    modport master (
        output req, din_vld, din, seach_end, overflow, underflow,
        input  gnt, done, ovf_o, udf_o, tmo_err, busy, srch, dtin, data_o
    );

    modport slave (
        input  req, din_vld, din, seach_end, overflow, underflow,
        output gnt, done, ovf_o, udf_o, tmo_err, busy, srch, dtin, data_o
    );
endinterface

// File: rtl/srch_arbiter.sv
// rtl/srch_arbiter.sv - round-robin arbiter sharing the search datapath; SRCH_ARB_TMO_EN enables the WAIT watchdog
module srch_arbiter #(
    parameter int NREQ  = 4,
    parameter int DW    = 8,
    parameter int DEPTH = 8,
    parameter int TMO   = 255
) (
    input logic           clk,
    input logic           reset,
    srch_arbiter_if.slave bus
);
    localparam int GW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int WCW = $clog2(DEPTH) + 1;
    localparam logic [WCW-1:0] WC_FULL = WCW'(DEPTH);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_GRANT = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    if (NREQ < 2 || NREQ > 8 || DEPTH < 1 || TMO < 1) begin : g_bad_cfg
        $error("srch_arbiter: unsupported parameter set");
    end

`ifdef SRCH_ARB_TMO_EN
    localparam int TW = ($clog2(TMO + 1) > 8) ? $clog2(TMO + 1) : 8;
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 1);
    logic [TW-1:0] tcnt;
    logic          tmo_r;
    logic          tmo_q;
`endif

    logic [2:0]      state;
    logic [GW-1:0]   g;
    logic [GW-1:0]   last;
    logic [GW-1:0]   pick;
    logic            found;
    int              rr_idx;
    logic [WCW-1:0]  wc;
    logic            lderr;
    logic            ovf_r;
    logic            udf_r;
    logic            cap_vld;
    logic [DW-1:0]   cap_data;
    logic            cur_vld;
    logic [DW-1:0]   cur_data;
    logic [NREQ-1:0] g_onehot;

    logic [NREQ-1:0] gnt_q;
    logic [NREQ-1:0] done_q;
    logic            ovf_q;
    logic            udf_q;
    logic            busy_q;
    logic            srch_q;
    logic            dtin_q;
    logic [DW-1:0]   data_q;

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        pick   = last;
        found  = 1'b0;
        rr_idx = 0;
        for (int k = 1; k <= NREQ; k++) begin
            rr_idx = (int'(last) + k) % NREQ;
            if (!found && bus.req[rr_idx]) begin
                pick  = rr_idx[GW-1:0];
                found = 1'b1;
            end
        end
    end

    always_comb begin
        g_onehot    = '0;
        g_onehot[g] = 1'b1;
        cur_vld     = bus.din_vld[g];
        cur_data    = bus.din[int'(g)*DW +: DW];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            g        <= '0;
            last     <= GW'(NREQ - 1);
            wc       <= '0;
            lderr    <= 1'b0;
            ovf_r    <= 1'b0;
            udf_r    <= 1'b0;
            cap_vld  <= 1'b0;
            cap_data <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            busy_q   <= 1'b0;
            srch_q   <= 1'b0;
            dtin_q   <= 1'b0;
            data_q   <= '0;
`ifdef SRCH_ARB_TMO_EN
            tcnt     <= '0;
            tmo_r    <= 1'b0;
            tmo_q    <= 1'b0;
`endif
        end else begin
            // Outputs are a registered image of the state this cycle.
            busy_q  <= (state != S_IDLE);
            gnt_q   <= (state != S_IDLE) ? g_onehot : '0;
            srch_q  <= (state == S_GRANT) || (state == S_LOAD);
            dtin_q  <= cap_vld;
            data_q  <= cap_data;
            done_q  <= (state == S_DONE) ? g_onehot : '0;
            ovf_q   <= (state == S_DONE) && ovf_r;
            udf_q   <= (state == S_DONE) && udf_r;
`ifdef SRCH_ARB_TMO_EN
            tmo_q   <= (state == S_DONE) && tmo_r;
`endif
            cap_vld <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (|bus.req) begin
                        g     <= pick;
                        state <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    state <= S_LOAD;
                end
                S_LOAD: begin
`ifdef SRCH_ARB_TMO_EN
                    tcnt <= '0;
`endif
                    // A word offered once the buffer is full is dropped and flagged.
                    if (wc == WC_FULL) begin
                        if (cur_vld) begin
                            lderr <= 1'b1;
                        end
                        state <= S_WAIT;
                    end else if (cur_vld) begin
                        cap_vld  <= 1'b1;
                        cap_data <= cur_data;
                        wc       <= wc + 1'b1;
                    end else if (wc != '0) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.seach_end) begin
                        ovf_r <= !bus.overflow || lderr;
                        udf_r <= bus.underflow;
`ifdef SRCH_ARB_TMO_EN
                        tmo_r <= 1'b0;
`endif
                        state <= S_DONE;
                    end
`ifdef SRCH_ARB_TMO_EN
                    else if (tcnt == TMO_LAST) begin
                        ovf_r <= 1'b0;
                        udf_r <= 1'b0;
                        tmo_r <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
`endif
                end
                S_DONE: begin
                    last  <= g;
                    lderr <= 1'b0;
                    wc    <= '0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt    = gnt_q;
    assign bus.done   = done_q;
    assign bus.ovf_o  = ovf_q;
    assign bus.udf_o  = udf_q;
    assign bus.busy   = busy_q;
    assign bus.srch   = srch_q;
    assign bus.dtin   = dtin_q;
    assign bus.data_o = data_q;
`ifdef SRCH_ARB_TMO_EN
    assign bus.tmo_err = tmo_q;
`else
    assign bus.tmo_err = 1'b0;
`endif
endmodule

// File: doc/srch_arbiter.md
# srch_arbiter

Round-robin scheduler that shares the single search/sort datapath (control unit, memory, counter, comparators) among NREQ requesters. It grants one requester at a time, steers that requester's load stream onto the control unit's `srch`/`dtin` inputs, and waits for `seach_end`. It then returns a one-cycle `done` plus the session's overflow/underflow status to the granted requester. It sits between the requester ports and the control unit, and is the only driver of `srch`, `dtin` and the load data bus.

## Interface
Parameters:
- `NREQ`, 4, number of requesters (2..8).
- `DW`, 8, load data width.
- `DEPTH`, 8, maximum words per session; matches the 3-bit encoder range.
- `TMO`, 255, WAIT-state watchdog limit in cycles (only with `SRCH_ARB_TMO_EN`).

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous reset, active-high.
- `req`  in  NREQ  session request, level; sampled only in IDLE.
- `din_vld`  in  NREQ  per-requester load data valid.
- `din`  in  NREQ*DW  per-requester load data; requester i occupies bits [i*DW +: DW].
- `gnt`  out  NREQ  one-hot grant; high from GRANT through DONE.
- `done`  out  NREQ  one-cycle completion pulse to the granted requester.
- `ovf_o`  out  1  session overflow status; valid while `done` is high.
- `udf_o`  out  1  session underflow status; valid while `done` is high.
- `tmo_err`  out  1  one-cycle pulse, coincident with `done`, when the session timed out.
- `busy`  out  1  high in every state except IDLE.
- `srch`  out  1  to control unit: search/load session active.
- `dtin`  out  1  to control unit: load word valid.
- `data_o`  out  DW  to control unit / memory: load word.
- `seach_end`  in  1  from control unit: search finished.
- `overflow`  in  1  from control unit; active-low.
- `underflow`  in  1  from control unit; active-high.

## Operation
- FSM states: IDLE, GRANT, LOAD, WAIT, DONE. All outputs are registered.
- **IDLE**
  - If `req != 0`, select the first set bit starting at `last+1` (mod NREQ), register its index `g`, and go to GRANT.
  - Otherwise stay in IDLE.
- **GRANT**
  - One cycle; `gnt[g]=1`, `srch=1`. Go to LOAD.
- **LOAD**
  - `srch=1`; `dtin` follows `din_vld[g]`; `data_o` follows `din[g]`.
  - The word counter `wc` (width clog2(DEPTH)+1) increments on each valid word.
  - Exit to WAIT when `din_vld[g]` falls after at least one word.
  - Exit to WAIT when `wc` reaches DEPTH. Further words are discarded (`dtin` forced 0) and sticky `lderr` is set.
  - A requester holding `din_vld` low indefinitely keeps LOAD; this does not count toward timeout.
- **WAIT**
  - `srch=0`, `dtin=0`.
  - On `seach_end=1`, capture `ovf = !overflow | lderr` and `udf = underflow`, then go to DONE.
- **DONE**
  - One cycle: `done[g]=1`, `ovf_o`/`udf_o` driven.
  - Set `last=g`, clear `lderr` and `wc`, go to IDLE. `gnt` drops on exit.
- Other requesters
  - `req` changes during a session are ignored.
  - Non-granted `din_vld`/`din` are ignored.
- **Reset**
  - State IDLE; `last=NREQ-1`, so requester 0 has first priority.
  - `wc=0`, `lderr=0`.
  - All outputs 0: `gnt`, `done`, `ovf_o`, `udf_o`, `tmo_err`, `busy`, `srch`, `dtin`, `data_o`.
  - Reset mid-session aborts the session with no `done` pulse.

## Timing
- `req` sampled high at edge t gives `gnt`/`srch`/`busy` high after edge t+1 (GRANT).
- LOAD path latency is one cycle:
  - `din_vld[g]`/`din[g]` sampled at edge n appear on `dtin`/`data_o` after edge n+1.
  - This satisfies the control unit's `srch & dtin` start condition.
- `seach_end` sampled at edge m gives `done`/`ovf_o`/`udf_o` after edge m+1, for exactly one cycle.
- At least one IDLE cycle separates consecutive sessions; back-to-back grant-to-grant spacing is ≥ 4 cycles.
- If `seach_end` is already high on WAIT entry, WAIT lasts one cycle.
- `seach_end` outside WAIT is ignored.

## Configuration
- `SRCH_ARB_TMO_EN` defined:
  - An 8-bit-plus watchdog counts WAIT cycles.
  - On reaching `TMO` without `seach_end`, go to DONE with `tmo_err=1`, `ovf_o=0`, `udf_o=0`.
  - The counter clears on WAIT entry.
- Not defined:
  - No watchdog; WAIT waits indefinitely.
  - `tmo_err` is tied 0.

## Test plan
- Reset, then `req=4'b0001`; requester 0 streams 3 words 0x11,0x22,0x33; `seach_end` pulses 5 cycles after load end with `overflow=1`, `underflow=0`.
  - Required: `gnt=0001`; `dtin` high 3 cycles carrying 0x11,0x22,0x33 one cycle delayed; `done=0001` one cycle later with `ovf_o=0`, `udf_o=0`.
- `req=4'b1111` held for 4 sessions after reset -> grant order 0,1,2,3, then 0 again; each `done` precedes the next `gnt` by ≥1 IDLE cycle.
- Requester 2 streams 10 words with DEPTH=8.
  - Required: exactly 8 `dtin` pulses, then WAIT; with `overflow=1` on `seach_end`, `done[2]` carries `ovf_o=1`.
- `overflow=0`, `underflow=1` at `seach_end` -> `done` pulse with `ovf_o=1`, `udf_o=1`.
- With `SRCH_ARB_TMO_EN`, TMO=255, and `seach_end` never asserted.
  - Required: `done` plus `tmo_err` pulse exactly 255 cycles after WAIT entry.
  - Without the macro, `busy` remains 1 after 1000 cycles.
- Assert `reset` one cycle during LOAD of requester 1.
  - Required: next cycle all outputs 0 and no `done`.
  - A subsequent `req=4'b0010` is granted normally.
